breakout_engine: RTL and testbench

//  Parametrised brick-breaker game engine for the 8x8 LED board design: paddle, ball, brick field, lives, BCD score.

---
 rtl/brk_pkg.sv | 12 +
 rtl/breakout_engine_bcd.sv | 46 ++++
 rtl/breakout_engine.sv | 234 +++++++++++++++++++++++
 tb/tb_breakout_engine.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/brk_pkg.sv
// Shared types for the brick-breaker engine: game states and signed ball direction.
package brk_pkg;

  typedef enum logic [1:0] {HELD, FLY, GAMEOVER, CLEARED} state_t;

  typedef logic signed [1:0] dir_t;

  localparam dir_t DIR_NEG  = 2'sb11;
  localparam dir_t DIR_ZERO = 2'sb00;
  localparam dir_t DIR_POS  = 2'sb01;

endpackage

// File: rtl/breakout_engine_bcd.sv
// Saturating BCD up-counter for the game score; sticks at all-9s, clr has priority over inc.
module bcd_sat_counter #(
  parameter int DIGITS = 2
) (
  input  logic                  buttonclk,
  input  logic                  reset,
  input  logic                  inc_i,
  input  logic                  clr_i,
  output logic [4*DIGITS-1:0]   bcd_o
);

  logic [4*DIGITS-1:0] bcd_q, bcd_d;

  always_comb begin
    logic carry;
    logic all9;
    bcd_d = bcd_q;
    carry = 1'b1;
    all9  = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (bcd_q[4*i +: 4] != 4'd9) all9 = 1'b0;
    end
    if (clr_i) begin
      bcd_d = '0;
    end else if (inc_i && !all9) begin
      for (int i = 0; i < DIGITS; i++) begin
        if (carry) begin
          if (bcd_q[4*i +: 4] == 4'd9) begin
            bcd_d[4*i +: 4] = 4'd0;
          end else begin
            bcd_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd1;
            carry = 1'b0;
          end
        end
      end
    end
  end

  always_ff @(posedge buttonclk) begin
    if (reset) bcd_q <= '0;
    else       bcd_q <= bcd_d;
  end

  assign bcd_o = bcd_q;

endmodule

// File: rtl/breakout_engine.sv
// Brick-breaker engine: paddle, ball, brick field, lives and BCD score on a COLS x ROWS grid.
// Optional BRK_SPEEDUP_EN: ball step period shrinks by one every SPEEDUP_EVERY bricks cleared.
module breakout_engine
  import brk_pkg::*;
#(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int BRICK_ROWS    = 2,
  parameter int PAD_W         = 3,
  parameter int LIVES         = 3,
  parameter int STEP_DIV      = 3,
  parameter int SCORE_DIGITS  = 2,
  parameter int SPEEDUP_EVERY = 4
) (
  input  logic                           buttonclk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           left,
  input  logic                           right,
  input  logic                           throw,
  input  logic                           serve,
  output logic [$clog2(COLS)-1:0]        pad_x,
  output logic [$clog2(COLS)-1:0]        ball_x,
  output logic [$clog2(ROWS)-1:0]        ball_y,
  output logic [BRICK_ROWS*COLS-1:0]     bricks,
  output logic [$clog2(LIVES+1)-1:0]     lives,
  output logic [4*SCORE_DIGITS-1:0]      score_bcd,
  output logic                           held,
  output logic                           game_over,
  output logic                           cleared
);

  localparam int XW    = $clog2(COLS);
  localparam int YW    = $clog2(ROWS);
  localparam int LW    = $clog2(LIVES + 1);
  localparam int NB    = BRICK_ROWS * COLS;
  localparam int NBW   = (NB > 1) ? $clog2(NB) : 1;
  localparam int BROW0 = ROWS - BRICK_ROWS;
  localparam int CW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [XW-1:0] PAD_MAX  = XW'(COLS - PAD_W);
  localparam logic [XW-1:0] PAD_HALF = XW'(PAD_W / 2);
  localparam logic [XW-1:0] PAD_RST  = XW'((COLS - PAD_W) / 2);

  if (PAD_W < 3 || PAD_W % 2 == 0 || LIVES < 1 || STEP_DIV < 1 || SPEEDUP_EVERY < 1) begin : g_param_check
    $error("breakout_engine: invalid parameter set");
  end

  state_t           state_q, state_d;
  logic [XW-1:0]    pad_q, pad_d, bx_q, bx_d;
  logic [YW-1:0]    by_q, by_d;
  dir_t             dx_q, dx_d, dy_q, dy_d;
  logic [CW-1:0]    cnt_q, cnt_d, period_m1;
  logic [NB-1:0]    bricks_q, bricks_d, bricks_clr;
  logic [LW-1:0]    lives_q, lives_d;
  logic             score_inc, score_clr;

  logic [XW-1:0]    pad_mv, tx;
  logic [YW-1:0]    ty;
  dir_t             ndx, ndy;
  logic [NBW-1:0]   bidx;
  logic             hit_brick, on_pad;

`ifdef BRK_SPEEDUP_EN
  localparam int HMAX = STEP_DIV * SPEEDUP_EVERY;
  localparam int HW   = $clog2(HMAX + 1);
  logic [HW-1:0] hits_q, hits_d;
  int            slow;

  always_comb begin
    slow      = int'(hits_q) / SPEEDUP_EVERY;
    period_m1 = (slow >= STEP_DIV - 1) ? '0 : CW'(STEP_DIV - 1 - slow);
  end
`else
  assign period_m1 = CW'(STEP_DIV - 1);
`endif

  always_comb begin
    state_d   = state_q;
    pad_d     = pad_q;
    bx_d      = bx_q;
    by_d      = by_q;
    dx_d      = dx_q;
    dy_d      = dy_q;
    cnt_d     = cnt_q;
    bricks_d  = bricks_q;
    lives_d   = lives_q;
    score_inc = 1'b0;
    score_clr = 1'b0;
`ifdef BRK_SPEEDUP_EN
    hits_d    = hits_q;
`endif

    pad_mv = pad_q;
    if (left && !right && pad_q != '0)          pad_mv = pad_q - XW'(1);
    else if (right && !left && pad_q < PAD_MAX) pad_mv = pad_q + XW'(1);

    // Walls and ceiling reflect before the brick/paddle look-ahead.
    ndx = dx_q;
    ndy = dy_q;
    if ((bx_q == '0 && dx_q == DIR_NEG) || (bx_q == XW'(COLS - 1) && dx_q == DIR_POS)) ndx = -dx_q;
    if (by_q == YW'(ROWS - 1) && dy_q == DIR_POS) ndy = DIR_NEG;

    tx   = XW'(int'(bx_q) + int'(ndx));
    ty   = YW'(int'(by_q) + int'(ndy));
    bidx = NBW'((int'(ty) - BROW0) * COLS + int'(tx));
    hit_brick = 1'b0;
    if (int'(ty) >= BROW0) hit_brick = bricks_q[bidx];
    bricks_clr       = bricks_q;
    bricks_clr[bidx] = 1'b0;
    on_pad = (bx_q >= pad_q) && (bx_q <= pad_q + XW'(PAD_W - 1));

    if (start) begin
      unique case (state_q)
        HELD: begin
          pad_d = pad_mv;
          bx_d  = pad_mv + PAD_HALF;
          by_d  = YW'(1);
          if (throw) begin
            state_d = FLY;
            dx_d    = DIR_ZERO;
            dy_d    = DIR_POS;
            cnt_d   = '0;
          end
        end
        FLY: begin
          pad_d = pad_mv;
          if (cnt_q >= period_m1) begin
            cnt_d = '0;
            dx_d  = ndx;
            dy_d  = ndy;
            if (hit_brick) begin
              bricks_d  = bricks_clr;
              score_inc = 1'b1;
              dy_d      = -ndy;
`ifdef BRK_SPEEDUP_EN
              if (hits_q != HW'(HMAX)) hits_d = hits_q + HW'(1);
`endif
              if (bricks_clr == '0) state_d = CLEARED;
            end else if (by_q == YW'(1) && ndy == DIR_NEG) begin
              if (on_pad) begin
                dy_d = DIR_POS;
                by_d = YW'(2);
                if (bx_q == pad_q)                            dx_d = DIR_NEG;
                else if (bx_q == pad_q + XW'(PAD_W - 1))      dx_d = DIR_POS;
              end else begin
                lives_d = lives_q - LW'(1);
                dx_d    = DIR_ZERO;
                dy_d    = DIR_POS;
                if (lives_q == LW'(1)) begin
                  state_d = GAMEOVER;
                end else begin
                  state_d = HELD;
                  bx_d    = pad_mv + PAD_HALF;
                  by_d    = YW'(1);
                end
              end
            end else begin
              bx_d = tx;
              by_d = ty;
            end
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        GAMEOVER, CLEARED: begin
          if (serve) begin
            state_d  = HELD;
            bricks_d = '1;
            bx_d     = pad_q + PAD_HALF;
            by_d     = YW'(1);
            dx_d     = DIR_ZERO;
            dy_d     = DIR_POS;
            cnt_d    = '0;
            if (state_q == GAMEOVER) begin
              lives_d   = LW'(LIVES);
              score_clr = 1'b1;
`ifdef BRK_SPEEDUP_EN
              hits_d    = '0;
`endif
            end
          end
        end
      endcase
    end
  end

  always_ff @(posedge buttonclk) begin
    if (reset) begin
      state_q  <= HELD;
      pad_q    <= PAD_RST;
      bx_q     <= PAD_RST + PAD_HALF;
      by_q     <= YW'(1);
      dx_q     <= DIR_ZERO;
      dy_q     <= DIR_POS;
      cnt_q    <= '0;
      bricks_q <= '1;
      lives_q  <= LW'(LIVES);
`ifdef BRK_SPEEDUP_EN
      hits_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      pad_q    <= pad_d;
      bx_q     <= bx_d;
      by_q     <= by_d;
      dx_q     <= dx_d;
      dy_q     <= dy_d;
      cnt_q    <= cnt_d;
      bricks_q <= bricks_d;
      lives_q  <= lives_d;
`ifdef BRK_SPEEDUP_EN
      hits_q   <= hits_d;
`endif
    end
  end

  bcd_sat_counter #(.DIGITS(SCORE_DIGITS)) u_score (
    .buttonclk (buttonclk),
    .reset     (reset),
    .inc_i     (score_inc),
    .clr_i     (score_clr),
    .bcd_o     (score_bcd)
  );

  assign pad_x     = pad_q;
  assign ball_x    = bx_q;
  assign ball_y    = by_q;
  assign bricks    = bricks_q;
  assign lives     = lives_q;
  assign held      = (state_q == HELD);
  assign game_over = (state_q == GAMEOVER);
  assign cleared   = (state_q == CLEARED);

endmodule

// File: tb/tb_breakout_engine.sv
// Scoreboard bench for breakout_engine: random play against a behavioural game model.
module tb_breakout_engine;

  localparam int COLS = 8, ROWS = 6, BRICK_ROWS = 1, PAD_W = 3, LIVES = 2;
  localparam int STEP_DIV = 3, SCORE_DIGITS = 1, SPEEDUP_EVERY = 4;
  localparam int NB = BRICK_ROWS * COLS;
  localparam int SMAX = 10 ** SCORE_DIGITS - 1;
  localparam int S_HELD = 0, S_FLY = 1, S_GO = 2, S_CLR = 3;

  logic buttonclk = 1'b0;
  logic reset = 1'b1, start = 1'b0, left = 1'b0, right = 1'b0, throw = 1'b0, serve = 1'b0;
  logic [$clog2(COLS)-1:0]    pad_x, ball_x;
  logic [$clog2(ROWS)-1:0]    ball_y;
  logic [NB-1:0]              bricks;
  logic [$clog2(LIVES+1)-1:0] lives;
  logic [4*SCORE_DIGITS-1:0]  score_bcd;
  logic held, game_over, cleared;

  always #5 buttonclk = ~buttonclk;

  breakout_engine #(
    .COLS(COLS), .ROWS(ROWS), .BRICK_ROWS(BRICK_ROWS), .PAD_W(PAD_W), .LIVES(LIVES),
    .STEP_DIV(STEP_DIV), .SCORE_DIGITS(SCORE_DIGITS), .SPEEDUP_EVERY(SPEEDUP_EVERY)
  ) dut (
    .buttonclk(buttonclk), .reset(reset), .start(start), .left(left), .right(right),
    .throw(throw), .serve(serve), .pad_x(pad_x), .ball_x(ball_x), .ball_y(ball_y),
    .bricks(bricks), .lives(lives), .score_bcd(score_bcd), .held(held),
    .game_over(game_over), .cleared(cleared)
  );

  typedef struct {
    int px, bx, by, lives, score, flags;
    logic [NB-1:0] bricks;
  } exp_t;

  exp_t exp_q[$];
  int n_cmp = 0, n_err = 0;

  // Behavioural game state: plain integers, decimal score, 2-D brick map.
  int m_st, m_px, m_bx, m_by, m_dx, m_dy, m_cnt, m_lives, m_score, m_hits;
  bit m_brick[BRICK_ROWS][COLS];

  function automatic void chk(string name, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic int bcd_of(int v);
    int r = 0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      r += (v % 10) << (4 * i);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic logic [NB-1:0] pack_bricks();
    logic [NB-1:0] b = '0;
    for (int r = 0; r < BRICK_ROWS; r++)
      for (int c = 0; c < COLS; c++) b[r*COLS+c] = m_brick[r][c];
    return b;
  endfunction

  function automatic int bricks_left();
    int n = 0;
    for (int r = 0; r < BRICK_ROWS; r++)
      for (int c = 0; c < COLS; c++) n += int'(m_brick[r][c]);
    return n;
  endfunction

  task automatic refill();
    for (int r = 0; r < BRICK_ROWS; r++)
      for (int c = 0; c < COLS; c++) m_brick[r][c] = 1'b1;
  endtask

  task automatic recentre();
    m_bx = m_px + PAD_W / 2; m_by = 1; m_dx = 0; m_dy = 1;
  endtask

  task automatic model_cycle(bit rst, bit st, bit l, bit r, bit t, bit sv);
    int npx, ndx, ndy, tx, ty, period;
    if (rst) begin
      m_st = S_HELD; m_px = (COLS - PAD_W) / 2; recentre(); m_cnt = 0;
      m_lives = LIVES; m_score = 0; m_hits = 0; refill();
      return;
    end
    if (!st) return;
    npx = m_px;
    if (l && !r && m_px > 0) npx = m_px - 1;
    else if (r && !l && m_px < COLS - PAD_W) npx = m_px + 1;
    case (m_st)
      S_HELD: begin
        m_px = npx; m_bx = npx + PAD_W / 2; m_by = 1;
        if (t) begin m_st = S_FLY; m_dx = 0; m_dy = 1; m_cnt = 0; end
      end
      S_FLY: begin
        period = STEP_DIV;
`ifdef BRK_SPEEDUP_EN
        period = STEP_DIV - m_hits / SPEEDUP_EVERY;
        if (period < 1) period = 1;
`endif
        m_cnt++;
        if (m_cnt >= period) begin
          m_cnt = 0;
          ndx = m_dx; ndy = m_dy;
          if ((m_bx == 0 && ndx < 0) || (m_bx == COLS - 1 && ndx > 0)) ndx = -ndx;
          if (m_by == ROWS - 1 && ndy > 0) ndy = -1;
          tx = m_bx + ndx; ty = m_by + ndy;
          if (ty >= ROWS - BRICK_ROWS && m_brick[ty-(ROWS-BRICK_ROWS)][tx]) begin
            m_brick[ty-(ROWS-BRICK_ROWS)][tx] = 1'b0;
            m_score = (m_score < SMAX) ? m_score + 1 : SMAX;
            m_hits++;
            m_dx = ndx; m_dy = -ndy;
            if (bricks_left() == 0) m_st = S_CLR;
          end else if (m_by == 1 && ndy < 0) begin
            if (m_bx >= m_px && m_bx < m_px + PAD_W) begin
              m_dy = 1; m_by = 2;
              m_dx = (m_bx == m_px) ? -1 : (m_bx == m_px + PAD_W - 1) ? 1 : ndx;
            end else begin
              m_lives--; m_dx = 0; m_dy = 1;
              if (m_lives == 0) m_st = S_GO;
              else begin m_st = S_HELD; m_bx = npx + PAD_W / 2; m_by = 1; end
            end
          end else begin
            m_bx = tx; m_by = ty; m_dx = ndx; m_dy = ndy;
          end
        end
        m_px = npx;
      end
      default: begin
        if (sv) begin
          if (m_st == S_GO) begin m_lives = LIVES; m_score = 0; m_hits = 0; end
          m_st = S_HELD; refill(); recentre(); m_cnt = 0;
        end
      end
    endcase
  endtask

  task automatic drive(bit rst, bit st, bit l, bit r, bit t, bit sv);
    exp_t e;
    @(negedge buttonclk);
    reset = rst; start = st; left = l; right = r; throw = t; serve = sv;
    model_cycle(rst, st, l, r, t, sv);
    e.px = m_px; e.bx = m_bx; e.by = m_by; e.lives = m_lives;
    e.score = bcd_of(m_score); e.bricks = pack_bricks();
    e.flags = (m_st == S_HELD) ? 4 : (m_st == S_GO) ? 2 : (m_st == S_CLR) ? 1 : 0;
    exp_q.push_back(e);
  endtask

  // Monitor: compares every registered output against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(posedge buttonclk); #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pad_x", int'(pad_x), e.px);
        chk("ball_x", int'(ball_x), e.bx);
        chk("ball_y", int'(ball_y), e.by);
        chk("bricks", int'(bricks), int'(e.bricks));
        chk("lives", int'(lives), e.lives);
        chk("score", int'(score_bcd), e.score);
        chk("flags", int'({held, game_over, cleared}), e.flags);
      end
    end
  end

  initial begin
    int pad_tbl[5] = '{3, 4, 5, 5, 5};
    int left_tbl[3] = '{4, 3, 2};
    int aim = 1, want;
    bit ai = 1'b1, rst, st, l, r, t, sv;

    drive(1, 0, 0, 0, 0, 0);
    drive(1, 1, 1, 0, 1, 1);
    @(posedge buttonclk); #2;
    chk("rst_pad", int'(pad_x), 2);
    chk("rst_ball_x", int'(ball_x), 3);
    chk("rst_ball_y", int'(ball_y), 1);
    chk("rst_bricks", int'(bricks), 255);
    chk("rst_lives", int'(lives), LIVES);
    chk("rst_held", int'(held), 1);

    for (int i = 0; i < 5; i++) begin
      drive(0, 1, 0, 1, 0, 0);
      @(posedge buttonclk); #2;
      chk("pad_right", int'(pad_x), pad_tbl[i]);
      chk("ball_track", int'(ball_x), pad_tbl[i] + 1);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, 1, 0, 0, 0);
      @(posedge buttonclk); #2;
      chk("pad_left", int'(pad_x), left_tbl[i]);
    end

    drive(0, 1, 0, 0, 1, 0);
    @(posedge buttonclk); #2;
    chk("launch_held", int'(held), 0);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, 0, 0, 0);
    @(posedge buttonclk); #2;
    chk("first_step_x", int'(ball_x), 3);
    chk("first_step_y", int'(ball_y), 2);
    for (int i = 0; i < 12; i++) drive(0, 1, 0, 0, 0, 0);
    @(posedge buttonclk); #2;
    chk("brick_hit", int'(bricks[3]), 0);
    chk("score_one", int'(score_bcd), 1);

    for (int i = 0; i < 6; i++) drive(0, 0, 1, 0, 1, 1);

    for (int i = 0; i < 30000; i++) begin
      if (i % 600 == 0) ai = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 2999) == 0);
      st  = ($urandom_range(0, 15) != 0);
      l = 1'b0; r = 1'b0;
      if (m_st == S_FLY && m_dy > 0) aim = $urandom_range(0, PAD_W - 1);
      if (ai && m_st == S_FLY && m_dy < 0) begin
        want = m_bx - aim;
        if (want < 0) want = 0;
        if (want > COLS - PAD_W) want = COLS - PAD_W;
        if (want < m_px) l = 1'b1;
        else if (want > m_px) r = 1'b1;
      end else begin
        l = ($urandom_range(0, 3) == 0);
        r = ($urandom_range(0, 3) == 0);
      end
      t  = (m_st == S_HELD) ? ($urandom_range(0, 7) == 0) : ($urandom_range(0, 31) == 0);
      sv = ($urandom_range(0, 9) == 0);
      drive(rst, st, l, r, t, sv);
    end

    for (int k = 0; k < 4 && exp_q.size() > 0; k++) @(posedge buttonclk);
    #2;
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
